sw_alloc: RTL and testbench
===========================

# sw_alloc

Switch allocator for the router. It sits between the per-port input receivers (`sw_req`/`sw_chnl`/`sw_gnt` interface) and the crossbar/output transmitters. It grants each output channel to one requesting input port at a time, using a per-output round-robin arbiter. It drives the crossbar select lines and holds each grant until the output's transmitter reports packet completion.

## Interface

Parameters:
- `PORTS`, 5, number of router ports; inputs and outputs are both indexed 0..PORTS-1.
- `CHANNEL_BITS`, 3, width of a channel/port index; 2^CHANNEL_BITS ≥ PORTS.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `sw_req`  in  PORTS  per input port: level request for an output channel.
- `sw_chnl`  in  PORTS*CHANNEL_BITS  per input port: requested output index; input i occupies bits [i*CHANNEL_BITS +: CHANNEL_BITS].
- `sw_gnt`  out  PORTS  per input port: grant, registered, level.
- `tx_done`  in  PORTS  per output channel: one-cycle pulse from the transmitter marking the end of packet transfer.
- `xbar_sel`  out  PORTS*CHANNEL_BITS  per output channel: index of the input driving it.
- `xbar_vld`  out  PORTS  per output channel: `xbar_sel` is valid and the channel is allocated.
- `chnl_err`  out  PORTS  per input port: sticky flag; set when `sw_req` is high with `sw_chnl` ≥ PORTS.

## Operation

- Per output o, three-state FSM:
  - **IDLE**: arbitrate. Eligible inputs i have `sw_req[i]`=1, `sw_chnl[i]`=o, `served[i]`=0, and are not currently granted.
    - If any input is eligible: winner = first eligible input scanning ptr[o], ptr[o]+1, … mod PORTS.
    - Register `sw_gnt[winner]`=1, `xbar_sel[o]`=winner, `xbar_vld[o]`=1. Go to GRANT.
    - Set ptr[o] = (winner+1) mod PORTS.
  - **GRANT**: hold the grant.
    - Go to RELEASE on `tx_done[o]`=1, or when `sw_req[winner]` drops to 0 (abort).
    - Clear `sw_gnt[winner]` and `xbar_vld[o]`. `xbar_sel[o]` keeps its last value.
    - If released by `tx_done`, set `served[winner]`=1.
  - **RELEASE**: one dead cycle so the receiver can observe `sw_gnt` low. Then go to IDLE.
- `served[i]`: clears on any cycle with `sw_req[i]`=0. This blocks re-granting the same request level twice; a requester must drop `sw_req` for ≥1 cycle before its next request is seen.
- Each input requests exactly one output, so at most one output can grant a given input. Implementation must still guarantee `sw_gnt` is one-hot-or-zero per input.
- `sw_chnl` is sampled only in IDLE arbitration. Changes while granted are ignored.
- Out-of-range `sw_chnl` (≥ PORTS): the request is ignored and `chnl_err[i]` is set. The flag clears only on reset.
- `tx_done[o]` while output o is in IDLE or RELEASE: ignored.
- Abort and `tx_done` in the same cycle: treated as `tx_done` (served set).
- ptr arithmetic: modulo PORTS, not 2^CHANNEL_BITS; wrap from PORTS-1 to 0.

## Timing

- Reset (`reset`=0 at posedge): all FSMs → IDLE; ptr → 0; served → 0.
  - Outputs: `sw_gnt`=0, `xbar_sel`=0, `xbar_vld`=0, `chnl_err`=0.
  - Takes effect on the next cycle regardless of any transfer in flight. Grants drop without waiting for `tx_done`.
- Grant latency: request valid at edge N → `sw_gnt`/`xbar_vld` high after edge N+1 (1 cycle).
- Release latency: `tx_done` at edge M → `sw_gnt` low after edge M+1. The earliest re-grant of output o is visible after edge M+3 (RELEASE, then IDLE arbitration).
- Independent outputs arbitrate in parallel in the same cycle; up to PORTS grants can be active at once.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan

- **Single request.** PORTS=5. Input 2 requests chnl 4 → `sw_gnt`=00100 and `xbar_sel[4]`=2, `xbar_vld[4]`=1, one cycle later. `tx_done[4]` pulse → `sw_gnt`=0 next cycle. Input 2 holds `sw_req` → no re-grant until `sw_req` drops ≥1 cycle.
- **Round-robin.** Inputs 0, 1, 3 hold requests for chnl 2, each re-raising after release. Grant order is 0, 1, 3, 0, …. There is exactly one RELEASE cycle between consecutive grants.
- **Parallel outputs.** Input 0→chnl 1, input 1→chnl 0, input 4→chnl 3 in the same cycle → all three granted in the same cycle. The `xbar_sel` fields match.
- **Abort and simultaneity.** Granted input drops `sw_req` → grant clears next cycle with served=0. `tx_done` coincident with the drop → served set and the next arbitration proceeds normally.
- **Error.** Input 1 requests `sw_chnl`=6 → never granted, `chnl_err[1]`=1 and stays set. Other ports are unaffected.
- **Reset mid-transfer.** Three active grants, then `reset`=0 for one cycle → all outputs 0 next cycle. After release, the first arbitration starts from ptr=0.

Source files
------------

// File: rtl/sw_alloc.sv
// sw_alloc: switch allocator for the router.
// Grants each output channel to one requesting input port at a time using a
// per-output round-robin arbiter. It drives the crossbar select lines and
// holds each grant until the output's transmitter reports packet completion.
//
// Handshake (sw_req / sw_gnt): level-based. An input raises sw_req with its
// target output on sw_chnl and holds both. sw_gnt rises one cycle after the
// request is accepted and stays high until tx_done on that output, or until
// the input drops sw_req (abort). After a completed packet the same request
// level is never granted twice; the input must drop sw_req for at least one
// cycle before its next request is seen.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-low reset
//   sw_req     per input: level request
//   sw_chnl    per input: requested output index, input i at [i*CB +: CB]
//   sw_gnt     per input: registered grant level
//   tx_done    per output: one-cycle end-of-packet pulse
//   xbar_sel   per output: index of the input driving it
//   xbar_vld   per output: channel allocated, xbar_sel valid
//   chnl_err   per input: sticky out-of-range channel request flag
//   fsm_state  per output: 2-bit allocator state (debug), output o at [2*o +: 2]
module sw_alloc #(
  parameter int PORTS        = 5,
  parameter int CHANNEL_BITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PORTS-1:0]             sw_req,
  input  logic [PORTS*CHANNEL_BITS-1:0] sw_chnl,
  output logic [PORTS-1:0]             sw_gnt,
  input  logic [PORTS-1:0]             tx_done,
  output logic [PORTS*CHANNEL_BITS-1:0] xbar_sel,
  output logic [PORTS-1:0]             xbar_vld,
  output logic [PORTS-1:0]             chnl_err,
  output logic [2*PORTS-1:0]           fsm_state
);

  localparam int CB = CHANNEL_BITS;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [CB:0]   PORTS_W = (CB+1)'(PORTS);
  localparam logic [CB-1:0] LAST    = CB'(PORTS - 1);

  logic [1:0]    state_q [PORTS];
  logic [1:0]    state_d [PORTS];
  logic [CB-1:0] ptr_q   [PORTS];
  logic [CB-1:0] ptr_d   [PORTS];
  logic [CB-1:0] sel_q   [PORTS];
  logic [CB-1:0] sel_d   [PORTS];
  logic [CB-1:0] chnl    [PORTS];
  logic [PORTS-1:0] in_range;
  logic [PORTS-1:0] served_q, served_d;
  logic [PORTS-1:0] gnt_d, vld_d, err_d;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      chnl[i]     = sw_chnl[i*CB +: CB];
      in_range[i] = ({1'b0, chnl[i]} < PORTS_W);
    end
  end

  always_comb begin
    logic          found;
    logic [CB:0]   idx;
    logic [CB-1:0] cand;
    logic [CB-1:0] win;
    found    = 1'b0;
    idx      = '0;
    cand     = '0;
    win      = '0;
    gnt_d    = sw_gnt;
    vld_d    = xbar_vld;
    err_d    = chnl_err | (sw_req & ~in_range);
    // A low request level re-arms the input; a tx_done set below wins over this.
    served_d = served_q & sw_req;
    for (int o = 0; o < PORTS; o++) begin
      state_d[o] = state_q[o];
      ptr_d[o]   = ptr_q[o];
      sel_d[o]   = sel_q[o];
      found      = 1'b0;
      win        = '0;
      case (state_q[o])
        ST_IDLE: begin
          // Scan ptr, ptr+1, ... wrapping at PORTS (not at 2^CB).
          for (int k = 0; k < PORTS; k++) begin
            idx = {1'b0, ptr_q[o]} + (CB+1)'(k);
            if (idx >= PORTS_W) idx = idx - PORTS_W;
            cand = idx[CB-1:0];
            if (!found && sw_req[cand] && (chnl[cand] == CB'(o)) &&
                !served_q[cand] && !sw_gnt[cand]) begin
              found = 1'b1;
              win   = cand;
            end
          end
          if (found) begin
            gnt_d[win] = 1'b1;
            vld_d[o]   = 1'b1;
            sel_d[o]   = win;
            ptr_d[o]   = (win == LAST) ? '0 : win + 1'b1;
            state_d[o] = ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (tx_done[o] || !sw_req[sel_q[o]]) begin
            gnt_d[sel_q[o]] = 1'b0;
            vld_d[o]        = 1'b0;
            state_d[o]      = ST_RELEASE;
            if (tx_done[o]) served_d[sel_q[o]] = 1'b1;
          end
        end
        ST_RELEASE: state_d[o] = ST_IDLE;
        default:    state_d[o] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_gnt   <= '0;
      xbar_vld <= '0;
      chnl_err <= '0;
      served_q <= '0;
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= ST_IDLE;
        ptr_q[o]   <= '0;
        sel_q[o]   <= '0;
      end
    end else begin
      sw_gnt   <= gnt_d;
      xbar_vld <= vld_d;
      chnl_err <= err_d;
      served_q <= served_d;
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= state_d[o];
        ptr_q[o]   <= ptr_d[o];
        sel_q[o]   <= sel_d[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      xbar_sel[o*CB +: CB] = sel_q[o];
      fsm_state[2*o +: 2]  = state_q[o];
    end
  end

endmodule

// File: tb/tb_sw_alloc.sv
// Testbench for sw_alloc: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural allocator model.
module tb_sw_alloc;

  localparam int P  = 5;
  localparam int CB = 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [P-1:0]    sw_req, tx_done, sw_gnt, xbar_vld, chnl_err;
  logic [P*CB-1:0] sw_chnl, xbar_sel;
  logic [2*P-1:0]  fsm_state;

  sw_alloc #(.PORTS(P), .CHANNEL_BITS(CB)) dut (
    .clk(clk), .reset(reset), .sw_req(sw_req), .sw_chnl(sw_chnl),
    .sw_gnt(sw_gnt), .tx_done(tx_done), .xbar_sel(xbar_sel),
    .xbar_vld(xbar_vld), .chnl_err(chnl_err), .fsm_state(fsm_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // stimulus state
  bit r_rst_n;
  bit r_req  [P];
  int r_chnl [P];
  bit r_done [P];

  // reference model: owner of each output (-1 none), dead cycle after release
  int m_owner [P];
  bit m_dead  [P];
  int m_ptr   [P];
  int m_sel   [P];
  bit m_served[P];
  bit m_err   [P];

  logic [P-1:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < P; i++) begin
      m_owner[i] = -1; m_dead[i] = 0; m_ptr[i] = 0;
      m_sel[i] = 0; m_served[i] = 0; m_err[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit old_served[P];
    bit granted[P];
    int w, cand;
    if (!r_rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < P; i++) begin
      old_served[i] = m_served[i];
      granted[i] = 0;
    end
    for (int o = 0; o < P; o++) if (m_owner[o] >= 0) granted[m_owner[o]] = 1;
    for (int i = 0; i < P; i++) begin
      if (r_req[i] && r_chnl[i] >= P) m_err[i] = 1;
      if (!r_req[i]) m_served[i] = 0;
    end
    for (int o = 0; o < P; o++) begin
      if (m_owner[o] >= 0) begin
        w = m_owner[o];
        if (r_done[o] || !r_req[w]) begin
          m_owner[o] = -1;
          m_dead[o] = 1;
          if (r_done[o]) m_served[w] = 1;
        end
      end else if (m_dead[o]) begin
        m_dead[o] = 0;
      end else begin
        for (int k = 0; k < P; k++) begin
          cand = (m_ptr[o] + k) % P;
          if (r_req[cand] && r_chnl[cand] == o && !old_served[cand] && !granted[cand]) begin
            m_owner[o] = cand;
            m_sel[o] = cand;
            m_ptr[o] = (cand + 1) % P;
            break;
          end
        end
      end
    end
  endfunction

  // driver: one clock cycle with full output comparison afterwards
  task automatic cycle();
    logic [P-1:0]    e_gnt, e_vld, e_err;
    logic [P*CB-1:0] e_sel;
    int s;
    @(negedge clk);
    reset = r_rst_n;
    for (int i = 0; i < P; i++) begin
      sw_req[i] = r_req[i];
      sw_chnl[i*CB +: CB] = r_chnl[i][CB-1:0];
      tx_done[i] = r_done[i];
    end
    @(posedge clk);
    model_step();
    e_gnt = '0;
    for (int o = 0; o < P; o++) begin
      if (m_owner[o] >= 0) e_gnt[m_owner[o]] = 1'b1;
      e_vld[o] = (m_owner[o] >= 0);
      s = m_sel[o];
      e_sel[o*CB +: CB] = s[CB-1:0];
      e_err[o] = m_err[o];
    end
    exp_q.push_back(e_gnt);
    #1;
    check("sw_gnt",   32'(sw_gnt),   32'(exp_q.pop_front()));
    check("xbar_vld", 32'(xbar_vld), 32'(e_vld));
    check("xbar_sel", 32'(xbar_sel), 32'(e_sel));
    check("chnl_err", 32'(chnl_err), 32'(e_err));
  endtask

  task automatic clear_stim();
    r_rst_n = 1;
    for (int i = 0; i < P; i++) begin
      r_req[i] = 0; r_chnl[i] = 0; r_done[i] = 0;
    end
  endtask

  task automatic reset_pulse();
    clear_stim();
    r_rst_n = 0;
    cycle();
    r_rst_n = 1;
  endtask

  int ord[$];
  bit prev_vld;

  initial begin
    model_reset();
    // reset state
    reset_pulse();
    check("reset_gnt", 32'(sw_gnt), 32'h0);
    check("reset_vld", 32'(xbar_vld), 32'h0);

    // single request: input 2 -> output 4
    r_req[2] = 1; r_chnl[2] = 4;
    cycle();
    check("single_gnt", 32'(sw_gnt), 32'h04);
    check("single_sel4", 32'(xbar_sel[4*CB +: CB]), 32'd2);
    cycle();
    r_done[4] = 1;
    cycle();
    r_done[4] = 0;
    check("single_release", 32'(sw_gnt), 32'h0);
    repeat (3) cycle();
    check("single_no_regrant", 32'(sw_gnt), 32'h0);
    r_req[2] = 0;
    cycle();
    r_req[2] = 1;
    cycle();
    check("single_regrant", 32'(sw_gnt), 32'h04);
    // abort, then abort coincident with tx_done
    r_req[2] = 0;
    cycle();
    check("abort_gnt", 32'(sw_gnt), 32'h0);
    r_req[2] = 1;
    repeat (3) cycle();
    r_req[2] = 0; r_done[4] = 1;
    cycle();
    r_done[4] = 0;
    r_req[2] = 1;
    repeat (3) cycle();

    // round robin: inputs 0, 1, 3 on output 2
    reset_pulse();
    prev_vld = 0;
    for (int c = 0; c < 30; c++) begin
      r_done[2] = (m_owner[2] >= 0);
      r_req[0] = !m_served[0]; r_chnl[0] = 2;
      r_req[1] = !m_served[1]; r_chnl[1] = 2;
      r_req[3] = !m_served[3]; r_chnl[3] = 2;
      cycle();
      if (xbar_vld[2] && !prev_vld) ord.push_back(int'(xbar_sel[2*CB +: CB]));
      prev_vld = xbar_vld[2];
    end
    check("rr_0", 32'(ord.size() > 0 ? ord[0] : 255), 32'd0);
    check("rr_1", 32'(ord.size() > 1 ? ord[1] : 255), 32'd1);
    check("rr_2", 32'(ord.size() > 2 ? ord[2] : 255), 32'd3);
    check("rr_3", 32'(ord.size() > 3 ? ord[3] : 255), 32'd0);

    // parallel outputs, then reset mid-transfer
    reset_pulse();
    r_req[0] = 1; r_chnl[0] = 1;
    r_req[1] = 1; r_chnl[1] = 0;
    r_req[4] = 1; r_chnl[4] = 3;
    cycle();
    check("par_gnt", 32'(sw_gnt), 32'h13);
    check("par_vld", 32'(xbar_vld), 32'h0b);
    check("par_sel1", 32'(xbar_sel[1*CB +: CB]), 32'd0);
    check("par_sel0", 32'(xbar_sel[0*CB +: CB]), 32'd1);
    check("par_sel3", 32'(xbar_sel[3*CB +: CB]), 32'd4);
    r_rst_n = 0;
    cycle();
    r_rst_n = 1;
    check("midrst_gnt", 32'(sw_gnt), 32'h0);
    check("midrst_sel", 32'(xbar_sel), 32'h0);
    cycle();
    check("midrst_regrant", 32'(sw_gnt), 32'h13);

    // out-of-range channel
    clear_stim();
    cycle();
    r_req[1] = 1; r_chnl[1] = 6;
    r_req[2] = 1; r_chnl[2] = 4;
    repeat (2) cycle();
    check("err_flag", 32'(chnl_err), 32'h02);
    check("err_gnt", 32'(sw_gnt), 32'h04);
    r_req[1] = 0;
    repeat (3) cycle();
    check("err_sticky", 32'(chnl_err), 32'h02);

    // randomized traffic
    reset_pulse();
    for (int c = 0; c < 3000; c++) begin
      r_rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < P; i++) begin
        if (r_req[i]) begin
          if (m_served[i] || $urandom_range(0, 9) == 0) r_req[i] = 0;
          else if ($urandom_range(0, 19) == 0) r_chnl[i] = $urandom_range(0, P-1);
        end else if ($urandom_range(0, 2) == 0) begin
          r_req[i] = 1;
          r_chnl[i] = ($urandom_range(0, 15) == 0) ? $urandom_range(P, 7) : $urandom_range(0, P-1);
        end
        r_done[i] = ($urandom_range(0, 3) == 0);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
